// File: rtl/mux2_reg.sv
// Registered 2:1 selector with a one-entry valid/ready output stage.
// Optional even-parity output when MUX2_REG_PARITY_EN is defined.
module mux2_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             sel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
`ifdef MUX2_REG_PARITY_EN
  ,
  output logic             out_parity_o
`endif
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] selected;
  logic             accept;

  assign selected   = sel_i ? in1_i : in0_i;
  // Stage frees up when empty or being drained this cycle.
  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    if (accept) begin
      dout_d  = selected;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout_o      = dout_q;
  assign out_valid_o = valid_q;

`ifdef MUX2_REG_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^selected;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity_o = parity_q;
`endif

endmodule

// File: tb/tb_mux2_reg.sv
// Directed testbench for mux2_reg: a WIDTH=1 and a WIDTH=4 instance share one clock.
// Parity checks run only when MUX2_REG_PARITY_EN is defined.
module tb_mux2_reg;

  logic       clk;
  logic       rst;

  logic       in0A, in1A, selA, ivA, orA;
  logic       irA, doutA, ovA;

  logic [3:0] in0B, in1B;
  logic       selB, ivB, orB;
  logic       irB, ovB;
  logic [3:0] doutB;

  int compared;
  int mismatched;

`ifdef MUX2_REG_PARITY_EN
  logic parA, parB;
`endif

  mux2_reg #(.WIDTH(1)) dutA (
    .clk_i(clk), .rst_i(rst),
    .in0_i(in0A), .in1_i(in1A), .sel_i(selA),
    .in_valid_i(ivA), .in_ready_o(irA),
    .dout_o(doutA), .out_valid_o(ovA), .out_ready_i(orA)
`ifdef MUX2_REG_PARITY_EN
    , .out_parity_o(parA)
`endif
  );

  mux2_reg #(.WIDTH(4)) dutB (
    .clk_i(clk), .rst_i(rst),
    .in0_i(in0B), .in1_i(in1B), .sel_i(selB),
    .in_valid_i(ivB), .in_ready_o(irB),
    .dout_o(doutB), .out_valid_o(ovB), .out_ready_i(orB)
`ifdef MUX2_REG_PARITY_EN
    , .out_parity_o(parB)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in0A = 1'b1; in1A = 1'b0; selA = 1'b0; ivA = 1'b1; orA = 1'b1;
    in0B = 4'h3; in1B = 4'hC; selB = 1'b0; ivB = 1'b1; orB = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      compared++;
      if (doutA !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_doutA cyc%0d: got %b want 0", c, doutA);
      end
      compared++;
      if (ovA !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_validA cyc%0d: got %b want 0", c, ovA);
      end
      compared++;
      if (doutB !== 4'h0 || ovB !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_B cyc%0d: got dout=%h valid=%b want 0/0", c, doutB, ovB);
      end
`ifdef MUX2_REG_PARITY_EN
      compared++;
      if (parA !== 1'b0 || parB !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_parity cyc%0d: got %b/%b want 0/0", c, parA, parB);
      end
`endif
    end
    rst = 1'b0;
    ivA = 1'b0;
    ivB = 1'b0;
    #1;
    compared++;
    if (irA !== 1'b1 || irB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b/%b want 1/1", irA, irB);
    end
  endtask

  task automatic test_truth_table();
    // Index bits {sel,in1,in0}; expected selection for index 7..0.
    logic [7:0] expTable;
    logic [2:0] idx;
    expTable = 8'hCA;
    orA = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idx  = i[2:0];
      in0A = idx[0];
      in1A = idx[1];
      selA = idx[2];
      ivA  = 1'b1;
      tick();
      compared++;
      if (doutA !== expTable[i] || ovA !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL truth_%0d: got dout=%b valid=%b want %b/1", i, doutA, ovA, expTable[i]);
      end
    end
    ivA = 1'b0;
    tick();
    compared++;
    if (ovA !== 1'b0 || doutA !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL truth_drain: got valid=%b dout=%b want 0/1", ovA, doutA);
    end
  endtask

  task automatic test_inversion_carry();
    // {in0,in1,sel,expected}
    logic [3:0] vec [4];
    vec[0] = 4'b0_1_1_1;
    vec[1] = 4'b1_0_1_0;
    vec[2] = 4'b0_1_1_1;
    vec[3] = 4'b0_1_0_0;
    orA = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in0A = vec[i][3];
      in1A = vec[i][2];
      selA = vec[i][1];
      ivA  = 1'b1;
      tick();
      compared++;
      if (doutA !== vec[i][0] || ovA !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL invcarry_%0d: got dout=%b valid=%b want %b/1", i, doutA, ovA, vec[i][0]);
      end
    end
    ivA = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    orB = 1'b1;
    in0B = 4'h3; in1B = 4'h0; selB = 1'b0; ivB = 1'b1;
    tick();
    compared++;
    if (doutB !== 4'h3 || ovB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_accept: got dout=%h valid=%b want 3/1", doutB, ovB);
    end
    orB = 1'b0;
    in0B = 4'h0; in1B = 4'hC; selB = 1'b1; ivB = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      compared++;
      if (irB !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL bp_ready_%0d: got %b want 0", c, irB);
      end
      tick();
      compared++;
      if (doutB !== 4'h3 || ovB !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL bp_hold_%0d: got dout=%h valid=%b want 3/1", c, doutB, ovB);
      end
    end
    orB = 1'b1;
    #1;
    compared++;
    if (irB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_release_ready: got %b want 1", irB);
    end
    tick();
    compared++;
    if (doutB !== 4'hC || ovB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_release: got dout=%h valid=%b want C/1", doutB, ovB);
    end
    ivB = 1'b0;
    tick();
    compared++;
    if (ovB !== 1'b0 || doutB !== 4'hC) begin
      mismatched++;
      $display("[TB] FAIL bp_drain: got valid=%b dout=%h want 0/C", ovB, doutB);
    end
  endtask

  task automatic test_back_to_back();
    // Item k: in0=k, in1=15-k, sel=k[0]; nibble k holds the expected result.
    logic [63:0] expStream;
    logic [3:0]  k4;
    expStream = 64'h0E2C4A6886A4C2E0;
    orB = 1'b1;
    for (int k = 0; k < 16; k++) begin
      k4   = k[3:0];
      in0B = k4;
      in1B = 4'hF - k4;
      selB = k4[0];
      ivB  = 1'b1;
      tick();
      compared++;
      if (doutB !== expStream[4*k +: 4] || ovB !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL stream_%0d: got dout=%h valid=%b want %h/1", k, doutB, ovB, expStream[4*k +: 4]);
      end
    end
    ivB = 1'b0;
    tick();
    compared++;
    if (ovB !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stream_end: got valid=%b want 0", ovB);
    end
  endtask

  task automatic test_reset_mid_stall();
    orB = 1'b0;
    in0B = 4'h5; in1B = 4'hA; selB = 1'b0; ivB = 1'b1;
    tick();
    compared++;
    if (doutB !== 4'h5 || ovB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stall_fill: got dout=%h valid=%b want 5/1", doutB, ovB);
    end
    rst = 1'b1;
    selB = 1'b1;
    tick();
    compared++;
    if (doutB !== 4'h0 || ovB !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_reset: got dout=%h valid=%b want 0/0", doutB, ovB);
    end
    rst = 1'b0;
    ivB = 1'b0;
    orB = 1'b1;
    tick();
  endtask

`ifdef MUX2_REG_PARITY_EN
  task automatic test_parity();
    orB = 1'b1;
    in0B = 4'h0; in1B = 4'b0111; selB = 1'b1; ivB = 1'b1;
    tick();
    compared++;
    if (parB !== 1'b1 || doutB !== 4'b0111) begin
      mismatched++;
      $display("[TB] FAIL parity_0111: got par=%b dout=%h want 1/7", parB, doutB);
    end
    in0B = 4'b0110; in1B = 4'b0111; selB = 1'b0;
    tick();
    compared++;
    if (parB !== 1'b0 || doutB !== 4'b0110) begin
      mismatched++;
      $display("[TB] FAIL parity_0110: got par=%b dout=%h want 0/6", parB, doutB);
    end
    ivB = 1'b0;
    in0B = 4'b0001;
    tick();
    compared++;
    if (parB !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL parity_hold: got %b want 0", parB);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_truth_table();
    test_inversion_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef MUX2_REG_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
